// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: conditions the three push-buttons (2-flop
// synchroniser + debounce counter), arbitrates press events, sequences the
// tenths/seconds counter chain (CE/CLR) and drives the display hold line.
module stopwatch_ctrl #(
    parameter int DEB_BITS = 17,
    parameter bit SAT      = 1'b1
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       TICK,
    input  logic       BTN_SS,
    input  logic       BTN_LAP,
    input  logic       BTN_CLR,
    input  logic       AT_MAX,
    output logic       CE,
    output logic       CLR,
    output logic       HOLD,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STOP  = 2'b10,
        ST_SPLIT = 2'b11
    } state_e;

    localparam logic [DEB_BITS-1:0] CNT_MAX = {DEB_BITS{1'b1}};
    localparam logic [DEB_BITS-1:0] CNT_ONE = {{(DEB_BITS-1){1'b0}}, 1'b1};

    // Button lanes: bit 0 = start/stop, bit 1 = lap, bit 2 = clear.
    logic [2:0]          btn_raw_s;
    logic [2:0]          sync1_r;
    logic [2:0]          sync2_r;
    logic [2:0]          deb_lvl_r;
    logic [2:0]          deb_lvl_d_r;
    logic [DEB_BITS-1:0] deb_cnt_r [3];
    logic [2:0]          press_s;

    logic   ev_ss_s;
    logic   ev_lap_s;
    logic   ev_clr_s;
    logic   sat_stop_s;
    logic   counting_s;

    state_e state_r;
    state_e state_next_s;
    logic   clr_next_s;
    logic   clr_r;
    logic   hold_r;

    assign btn_raw_s = {BTN_CLR, BTN_LAP, BTN_SS};

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: the level only follows the synced input after it has
    // differed for a full counter wrap; any agreement restarts the count.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= {DEB_BITS{1'b0}};
            end
            deb_lvl_r   <= 3'b000;
            deb_lvl_d_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_lvl_r[i]) begin
                    deb_cnt_r[i] <= {DEB_BITS{1'b0}};
                end else if (deb_cnt_r[i] == CNT_MAX) begin
                    deb_lvl_r[i] <= sync2_r[i];
                    deb_cnt_r[i] <= {DEB_BITS{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + CNT_ONE;
                end
            end
            deb_lvl_d_r <= deb_lvl_r;
        end
    end

    // Rising edge of the debounced level is the press event; releases are silent.
    assign press_s = deb_lvl_r & ~deb_lvl_d_r;

    // Event arbitration (clear beats start/stop beats lap) and next-state logic.
    always_comb begin
        ev_clr_s     = press_s[2];
        ev_ss_s      = press_s[0] & ~press_s[2];
        ev_lap_s     = press_s[1] & ~press_s[0] & ~press_s[2];
        sat_stop_s   = SAT & TICK & AT_MAX;
        state_next_s = state_r;
        clr_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ev_clr_s) begin
                    clr_next_s = 1'b1;
                end else if (ev_ss_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ev_ss_s || sat_stop_s) begin
                    state_next_s = ST_STOP;
                end else if (ev_lap_s) begin
                    state_next_s = ST_SPLIT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SPLIT: begin
                if (ev_ss_s || sat_stop_s) begin
                    state_next_s = ST_STOP;
                end else if (ev_lap_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_SPLIT;
                end
            end
            ST_STOP: begin
                if (ev_clr_s) begin
                    state_next_s = ST_IDLE;
                    clr_next_s   = 1'b1;
                end else if (ev_ss_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                clr_next_s   = 1'b0;
            end
        endcase
    end

    // State register plus the registered clear pulse and display hold.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_r <= ST_IDLE;
            clr_r   <= 1'b0;
            hold_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            clr_r   <= clr_next_s;
            hold_r  <= (state_next_s == ST_SPLIT);
        end
    end

    // CE is combinational so each tick is forwarded in its own cycle; the
    // old state decides, so a stop event coincident with a tick still counts.
    assign counting_s = (state_r == ST_RUN) || (state_r == ST_SPLIT);
    assign CE         = TICK & counting_s & ~(SAT & AT_MAX) & ~clr_r;

    assign CLR   = clr_r;
    assign HOLD  = hold_r;
    assign STATE = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_BITS=4 (press latency 19 cycles).
// Two instances share inputs: one saturating, one wrapping.
module tb_stopwatch_ctrl;

    logic       CLK = 1'b0;
    logic       R;
    logic       TICK;
    logic       BTN_SS;
    logic       BTN_LAP;
    logic       BTN_CLR;
    logic       AT_MAX;
    logic       ce1, clr1, hold1;
    logic [1:0] st1;
    logic       ce0, clr0, hold0;
    logic [1:0] st0;

    int n_checks = 0;
    int n_fail   = 0;
    int ce_cnt   = 0;

    typedef struct {
        logic       tick;
        logic       at_max;
        logic       exp_ce;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs [12];

    stopwatch_ctrl #(.DEB_BITS(4), .SAT(1'b1)) dut (
        .CLK(CLK), .R(R), .TICK(TICK), .BTN_SS(BTN_SS), .BTN_LAP(BTN_LAP),
        .BTN_CLR(BTN_CLR), .AT_MAX(AT_MAX),
        .CE(ce1), .CLR(clr1), .HOLD(hold1), .STATE(st1)
    );

    stopwatch_ctrl #(.DEB_BITS(4), .SAT(1'b0)) dut0 (
        .CLK(CLK), .R(R), .TICK(TICK), .BTN_SS(BTN_SS), .BTN_LAP(BTN_LAP),
        .BTN_CLR(BTN_CLR), .AT_MAX(AT_MAX),
        .CE(ce0), .CLR(clr0), .HOLD(hold0), .STATE(st0)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Hold the given buttons for exactly one debounce latency; on return the
    // state update caused by the press event is visible.
    task automatic press(input logic ss, input logic lap, input logic clr);
        BTN_SS  = ss;
        BTN_LAP = lap;
        BTN_CLR = clr;
        repeat (19) cyc();
    endtask

    task automatic release_btns();
        BTN_SS  = 1'b0;
        BTN_LAP = 1'b0;
        BTN_CLR = 1'b0;
        repeat (20) cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b01};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b01};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'b01};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'b01};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b01};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b01};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'b01};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b01};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'b01};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'b01};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b01};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 2'b01};

        R = 1'b0; TICK = 1'b0; AT_MAX = 1'b0;
        BTN_SS = 1'b0; BTN_LAP = 1'b0; BTN_CLR = 1'b0;

        // Reset with buttons toggling
        for (int k = 0; k < 5; k++) begin
            cyc();
            BTN_SS  = ~BTN_SS;
            BTN_LAP = ~BTN_LAP;
            BTN_CLR = ~BTN_CLR;
            TICK    = 1'b1;
            #1;
            chk("rst_state", st1, 2'b00);
            chk("rst_ce", ce1, 1'b0);
            chk("rst_clr", clr1, 1'b0);
            chk("rst_hold", hold1, 1'b0);
        end
        BTN_SS = 1'b0; BTN_LAP = 1'b0; BTN_CLR = 1'b0; TICK = 1'b0;
        cyc();
        R = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rst_exit_clr", clr1, 1'b0);
            chk("rst_exit_state", st1, 2'b00);
        end

        // Debounce: short glitch ignored
        BTN_SS = 1'b1;
        repeat (10) cyc();
        BTN_SS = 1'b0;
        repeat (25) cyc();
        chk("glitch_state", st1, 2'b00);

        // Debounce: stable press, exact latency, no repeat while held
        BTN_SS = 1'b1;
        repeat (18) cyc();
        chk("deb_lat18", st1, 2'b00);
        cyc();
        chk("deb_lat19", st1, 2'b01);
        repeat (21) cyc();
        chk("deb_held", st1, 2'b01);
        BTN_SS = 1'b0;
        repeat (25) cyc();
        chk("deb_release", st1, 2'b01);

        // Run: table of tick / at_max vectors
        for (int i = 0; i < 12; i++) begin
            TICK   = vecs[i].tick;
            AT_MAX = vecs[i].at_max;
            #1;
            chk($sformatf("run_ce[%0d]", i), ce1, vecs[i].exp_ce);
            if (ce1 === 1'b1) ce_cnt++;
            cyc();
            TICK   = 1'b0;
            AT_MAX = 1'b0;
            chk($sformatf("run_state[%0d]", i), st1, vecs[i].exp_state);
        end
        chk("run_ce_count", ce_cnt, 7);

        // Stop, with a tick coincident with the start/stop event
        BTN_SS = 1'b1;
        repeat (18) cyc();
        TICK = 1'b1;
        #1;
        chk("ss_tick_ce", ce1, 1'b1);
        cyc();
        TICK = 1'b0;
        chk("stop_state", st1, 2'b10);
        release_btns();
        for (int k = 0; k < 3; k++) begin
            TICK = 1'b1;
            #1;
            chk("stop_ce", ce1, 1'b0);
            cyc();
            TICK = 1'b0;
            cyc();
        end

        // Split
        press(1'b1, 1'b0, 1'b0);
        chk("restart_state", st1, 2'b01);
        release_btns();
        press(1'b0, 1'b1, 1'b0);
        chk("split_state", st1, 2'b11);
        chk("split_hold", hold1, 1'b1);
        release_btns();
        TICK = 1'b1;
        #1;
        chk("split_ce", ce1, 1'b1);
        cyc();
        TICK = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        chk("unsplit_state", st1, 2'b01);
        chk("unsplit_hold", hold1, 1'b0);
        release_btns();
        press(1'b0, 1'b1, 1'b0);
        chk("split2_state", st1, 2'b11);
        release_btns();
        press(1'b1, 1'b0, 1'b0);
        chk("split_stop_state", st1, 2'b10);
        chk("split_stop_hold", hold1, 1'b0);
        release_btns();
        press(1'b1, 1'b0, 1'b0);
        chk("run_again", st1, 2'b01);
        release_btns();

        // Saturation vs wrap
        AT_MAX = 1'b1;
        TICK   = 1'b1;
        #1;
        chk("sat_ce", ce1, 1'b0);
        chk("wrap_ce", ce0, 1'b1);
        cyc();
        TICK   = 1'b0;
        AT_MAX = 1'b0;
        chk("sat_state", st1, 2'b10);
        chk("wrap_state", st0, 2'b01);

        // Asynchronous reset mid-count, no clear pulse on exit
        #1;
        R = 1'b0;
        #1;
        chk("async_rst_st0", st0, 2'b00);
        chk("async_rst_st1", st1, 2'b00);
        repeat (2) cyc();
        R = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst2_clr", clr1, 1'b0);
            chk("rst2_state", st1, 2'b00);
        end

        // Clear in IDLE
        press(1'b0, 1'b0, 1'b1);
        chk("idle_clr_pulse", clr1, 1'b1);
        chk("idle_clr_state", st1, 2'b00);
        cyc();
        chk("idle_clr_end", clr1, 1'b0);
        release_btns();

        // Clear + start/stop together in STOP: clear wins
        press(1'b1, 1'b0, 1'b0);
        release_btns();
        press(1'b1, 1'b0, 1'b0);
        chk("pre_clr_stop", st1, 2'b10);
        release_btns();
        press(1'b1, 1'b0, 1'b1);
        chk("prio_clr_pulse", clr1, 1'b1);
        chk("prio_state", st1, 2'b00);
        chk("prio_ce", ce1, 1'b0);
        cyc();
        chk("prio_clr_end", clr1, 1'b0);
        chk("prio_state2", st1, 2'b00);
        release_btns();

        // Clear ignored in RUN
        press(1'b1, 1'b0, 1'b0);
        chk("run_pre_clr", st1, 2'b01);
        release_btns();
        press(1'b0, 1'b0, 1'b1);
        chk("run_clr_state", st1, 2'b01);
        chk("run_clr_pulse", clr1, 1'b0);
        cyc();
        chk("run_clr_pulse2", clr1, 1'b0);
        release_btns();
        chk("run_clr_final", st1, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
